// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers for the MIPS Execute stage.
// One result bit per cycle; busy stalls the pipeline while an operation is in flight.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             abortE,
  input  logic             mthiE,
  input  logic             mtloE,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_t           state;
  logic             op_div;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg_res;
  logic             neg_rem;
  logic             div_zero;
  logic [CNTW-1:0]  cnt;
  logic [2*WIDTH-1:0] acc;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   dividend_orig;

  assign busy = (state != IDLE);

  // opE[0] selects unsigned; signed ops work on magnitudes and fix the sign at the end
  always_comb begin
    a_neg = ~opE[0] & srcaE[WIDTH-1];
    b_neg = ~opE[0] & srcbE[WIDTH-1];
    abs_a = a_neg ? -srcaE : srcaE;
    abs_b = b_neg ? -srcbE : srcbE;
  end

  // acc holds {partial, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mag_b};
    if (div_trial[WIDTH])
      div_next = {acc[2*WIDTH-2:0], 1'b0};
    else
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // The dividend is rebuilt from its magnitude and sign for the divide-by-zero result
  always_comb begin
    prod_fix      = neg_res ? -acc : acc;
    quot_fix      = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix       = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    dividend_orig = neg_rem ? -mag_a : mag_a;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_div   <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mthiE) hi <= srcaE;
          if (mtloE) lo <= srcaE;
          if (startE && !abortE) begin
            op_div   <= opE[1];
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= opE[1] & (srcbE == '0);
            cnt      <= '0;
            acc      <= {{WIDTH{1'b0}}, (opE[1] ? abs_a : abs_b)};
            state    <= RUN;
          end
        end
        RUN: begin
          if (abortE) begin
            state <= IDLE;
          end else begin
            acc <= op_div ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          if (!abortE) begin
            if (!op_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (div_zero) begin
              hi <= dividend_orig;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
            done <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: vector table over WIDTH=32 and WIDTH=8 instances,
// plus hand sequences for start-while-busy, abort, MTHI/MTLO and async reset.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start32 = 1'b0;
  logic        start8 = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        abort = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;

  logic        busy32, done32, busy8, done8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .startE(start32), .opE(op),
    .srcaE(srca), .srcbE(srcb), .abortE(abort), .mthiE(mthi), .mtloE(mtlo),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  mdu_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .startE(start8), .opE(op),
    .srcaE(srca[7:0]), .srcbE(srcb[7:0]), .abortE(1'b0), .mthiE(1'b0), .mtloE(1'b0),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    string       name;
    bit          w8;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_done(input bit w8);
    return w8 ? done8 : done32;
  endfunction

  function automatic logic sel_busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction

  function automatic logic [31:0] sel_hi(input bit w8);
    return w8 ? {24'h0, hi8} : hi32;
  endfunction

  function automatic logic [31:0] sel_lo(input bit w8);
    return w8 ? {24'h0, lo8} : lo32;
  endfunction

  // Present a start for one edge, then scramble operands (they need not stay stable)
  task automatic launch(input bit w8, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op   = o;
    srca = a;
    srcb = b;
    if (w8) start8 = 1'b1;
    else    start32 = 1'b1;
    tick();
    start32 = 1'b0;
    start8  = 1'b0;
    srca    = $urandom;
    srcb    = $urandom;
  endtask

  // Bounded wait for done; n counts edges after the start edge
  task automatic wait_done(input bit w8, input int n0, output int n);
    n = n0;
    while (!sel_done(w8) && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_check(input string tag, input bit w8, input int n,
                              input logic [31:0] eh, input logic [31:0] el);
    chk({tag, " latency"}, n, w8 ? 32'd9 : 32'd33);
    chk({tag, " done"}, {31'h0, sel_done(w8)}, 32'd1);
    chk({tag, " busy_end"}, {31'h0, sel_busy(w8)}, 32'd0);
    chk({tag, " hi"}, sel_hi(w8), eh);
    chk({tag, " lo"}, sel_lo(w8), el);
    tick();
    chk({tag, " done_pulse"}, {31'h0, sel_done(w8)}, 32'd0);
  endtask

  int n;
  int busy_gap;
  int done_seen;

  initial begin
    vecs.push_back('{"multu_max",  1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{"mult_m7x3",  1'b0, 2'b00, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB});
    vecs.push_back('{"divu_100_7", 1'b0, 2'b11, 32'd100,      32'd7,        32'd2,        32'd14});
    vecs.push_back('{"div_m7_2",   1'b0, 2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"divu_5_0",   1'b0, 2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF});
    vecs.push_back('{"div_min_m1", 1'b0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vecs.push_back('{"div_m7_0",   1'b0, 2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF});
    vecs.push_back('{"div_7_m2",   1'b0, 2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD});
    vecs.push_back('{"mult_m5xm6", 1'b0, 2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'd0,        32'd30});
    vecs.push_back('{"mult_maxmin",1'b0, 2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000});
    vecs.push_back('{"multu_2p32", 1'b0, 2'b01, 32'h00010000, 32'h00010000, 32'd1,        32'd0});
    vecs.push_back('{"w8_multu",   1'b1, 2'b01, 32'hFF,       32'hFF,       32'hFE,       32'h01});
    vecs.push_back('{"w8_mult",    1'b1, 2'b00, 32'hF9,       32'h03,       32'hFF,       32'hEB});
    vecs.push_back('{"w8_divu",    1'b1, 2'b11, 32'd100,      32'd7,        32'd2,        32'd14});
    vecs.push_back('{"w8_div_min", 1'b1, 2'b10, 32'h80,       32'hFF,       32'h00,       32'h80});
    vecs.push_back('{"w8_divu_0",  1'b1, 2'b11, 32'd5,        32'd0,        32'd5,        32'hFF});

    #12;
    chk("reset hi", hi32, 32'd0);
    chk("reset lo", lo32, 32'd0);
    chk("reset busy", {31'h0, busy32}, 32'd0);
    chk("reset done", {31'h0, done32}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      launch(vecs[i].w8, vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      chk({vecs[i].name, " busy_start"}, {31'h0, sel_busy(vecs[i].w8)}, 32'd1);
      busy_gap = 0;
      n = 1;
      while (!sel_done(vecs[i].w8) && n < 200) begin
        if (!sel_busy(vecs[i].w8)) busy_gap++;
        tick();
        n++;
      end
      chk({vecs[i].name, " busy_gap"}, busy_gap, 32'd0);
      finish_check(vecs[i].name, vecs[i].w8, n, vecs[i].hi, vecs[i].lo);
    end

    // Start request while busy must be ignored
    launch(1'b0, 2'b11, 32'd100, 32'd7);
    repeat (4) tick();
    op = 2'b01; srca = 32'd3; srcb = 32'd3; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    wait_done(1'b0, 5, n);
    finish_check("start_ignored", 1'b0, n, 32'd2, 32'd14);

    mthi = 1'b1; srca = 32'h1234;
    tick();
    mthi = 1'b0;
    chk("mthi idle", hi32, 32'h1234);
    mtlo = 1'b1; srca = 32'hABCD;
    tick();
    mtlo = 1'b0;
    chk("mtlo idle", lo32, 32'hABCD);

    // MTHI/MTLO while busy are ignored, then abort mid-RUN
    launch(1'b0, 2'b11, 32'd100, 32'd7);
    repeat (3) tick();
    mthi = 1'b1; mtlo = 1'b1; srca = 32'h55;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    chk("mtlo busy lo", lo32, 32'hABCD);
    chk("mthi busy hi", hi32, 32'h1234);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", {31'h0, busy32}, 32'd0);
    chk("abort hi", hi32, 32'h1234);
    chk("abort lo", lo32, 32'hABCD);
    done_seen = 0;
    repeat (40) begin
      tick();
      if (done32) done_seen++;
    end
    chk("abort no_done", done_seen, 32'd0);
    chk("abort hi_later", hi32, 32'h1234);

    // Abort in the same idle cycle as start suppresses the start
    abort = 1'b1;
    launch(1'b0, 2'b01, 32'd3, 32'd3);
    abort = 1'b0;
    chk("abort_start busy", {31'h0, busy32}, 32'd0);

    // MTHI alongside start: HI written now, overwritten by the result
    mthi = 1'b1;
    launch(1'b0, 2'b01, 32'h99, 32'd2);
    mthi = 1'b0;
    chk("mthi_start hi", hi32, 32'h99);
    chk("mthi_start busy", {31'h0, busy32}, 32'd1);
    wait_done(1'b0, 0, n);
    finish_check("mthi_start", 1'b0, n, 32'd0, 32'h132);

    // Asynchronous reset mid-RUN clears outputs without a clock edge
    launch(1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (5) tick();
    chk("pre_reset hi", hi32, 32'd0);
    chk("pre_reset lo", lo32, 32'h132);
    #2 reset = 1'b1;
    #1;
    chk("async_reset busy", {31'h0, busy32}, 32'd0);
    chk("async_reset hi", hi32, 32'd0);
    chk("async_reset lo", lo32, 32'd0);
    chk("async_reset done", {31'h0, done32}, 32'd0);
    #2 reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      tick();
      if (done32) done_seen++;
    end
    chk("reset no_done", done_seen, 32'd0);
    chk("reset lo_later", lo32, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
